macs_array: RTL and testbench
=============================

# macs_array

Four-lane multiply/accumulate datapath that sits directly downstream of the instruction controller. It consumes the controller's `short_data`, `long_data`, `add_data`, `macs_mode`, `macs_signal` and `macs_en` outputs and returns `macs_result`. Each lane computes products or additions modulo 2^16 for the Frodo matrix operations (A·S + E style) and accumulates them over a programmable inner-product length.

## Interface
- `ACC_DEPTH`, 640, number of accumulated terms per output (inner dimension n); legal range 1..2047
- `LOGQ`, 15, modulus exponent; used only when `MACS_MODQ_EN` is defined; legal range 1..16
- `clk`  in  1  clock; single clock domain
- `rstn`  in  1  asynchronous active-low reset
- `macs_en`  in  1  term valid; operands sampled on the rising edge while high
- `macs_mode`  in  1  0 = multiply term, 1 = add term
- `macs_signal`  in  1  0 = add term to accumulator, 1 = subtract term
- `short_data`  in  32  four signed 8-bit operands; lane i = bits [8i+7:8i]
- `long_data`  in  64  four 16-bit operands; lane i = bits [16i+15:16i]
- `add_data`  in  64  four 16-bit addends, same lane packing as `long_data`
- `acc_clr`  in  1  synchronous clear of accumulators and term counter
- `macs_result`  out  64  four 16-bit accumulators, lane packing as `long_data`
- `result_valid`  out  1  one-cycle pulse: `macs_result` holds a completed ACC_DEPTH-term sum

## Operation
- Lane term, mode 0: `sext16(short_i) * long_i`, low 16 bits kept. Mode 1: `add_data_i`; `short_data` is ignored.
- `macs_signal` = 1: the term is negated (two's complement mod 2^16) before accumulation.
- Stage 1 (S1) registers all four signed terms and `s1_valid` = `macs_en`.
- Stage 2 (S2): if `s1_valid`, `acc_i <= base_i + term_i` (mod 2^16).
  - `base_i` = 0 when the term counter is 0, otherwise `acc_i`.
  - This gives clear-then-add for the first term of each sum.
- Term counter `cnt` (11 bits) increments on each S2 accumulation.
  - When the accumulation being written is term number ACC_DEPTH, `cnt` returns to 0 and `result_valid` is asserted on the following cycle.
  - `macs_result` holds the completed sum until the next accumulation.
- `acc_clr`: `acc_i` <= 0, `cnt` <= 0, and the S1 term is discarded, all on the same edge.
  - `acc_clr` wins over a simultaneous S2 accumulation.
  - An operand presented with `macs_en` on the same edge as `acc_clr` is still captured into S1.
- `macs_en` low with `s1_valid` low: accumulators hold.
- Gaps between terms of any length are allowed; the sum continues across gaps.
- `macs_result` is driven directly from the accumulator registers (no combinational path from inputs).

## Timing
- Reset values: `acc_i` = 0, `cnt` = 0, `s1_valid` = 0, `macs_result` = 64'h0, `result_valid` = 0.
- Reset asserted mid-sum discards all state; the first term after reset starts a new sum.
- Latency: operands sampled at edge N; `macs_result` reflects them after edge N+1.
- `result_valid` is high in the cycle after the edge that wrote term ACC_DEPTH (edge N+1), deasserted after one cycle.
- Throughput: one term per cycle, back-to-back, with no stall.
- Back-to-back sums: term 1 of sum k+1 may arrive on the cycle right after term ACC_DEPTH of sum k.
  - Its accumulation edge ends the `result_valid` window and overwrites `macs_result` with term 1 of sum k+1.
- ACC_DEPTH = 1: every accumulation produces `result_valid`.

## Configuration
- `MACS_MODQ_EN` defined: every S2 write masks the accumulators to the low LOGQ bits; upper bits read 0.
  - `result_valid` timing is unchanged.
- Not defined: full 16-bit wrap; LOGQ is ignored.

## Test plan
- Reset, then one mode-0 term: short = {8'hFF,8'h02,8'h01,8'h00}, long = 4×16'h0003, ACC_DEPTH = 1 -> after edge N+1, `macs_result` = {16'hFFFD,16'h0006,16'h0003,16'h0000} and `result_valid` pulses once.
- ACC_DEPTH = 4, four back-to-back mode-0 terms with short = 1, long = 16'h4000 -> lanes = 16'h0000 (wrap) with `result_valid` exactly after the 4th; with `MACS_MODQ_EN` and LOGQ = 15, the same result.
- Mode 1 `add_data` = 16'h0005 with `macs_signal` = 1 after a mode-0 sum of 16'h0003 (ACC_DEPTH = 2) -> lanes = 16'hFFFE, `result_valid` pulses.
- `acc_clr` on the same edge as an S2 accumulation -> lanes = 0 and `cnt` = 0; the next term reloads rather than adds.
- Terms separated by random gaps of 0..5 idle cycles, ACC_DEPTH = 640 -> `result_valid` occurs only after term 640; sums match a reference model mod 2^16.
- Assert `rstn` mid-sum after 3 terms -> all outputs are 0 immediately; the subsequent sum is unaffected by earlier terms.

Source files
------------

// File: rtl/macs_array.sv
// ============================================================================
// Module      : macs_array
// Description : Four-lane 16-bit multiply/accumulate datapath with a
//               programmable inner-product length (ACC_DEPTH terms per sum).
//               Optional macro MACS_MODQ_EN masks accumulators to LOGQ bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module macs_array #(
  parameter int ACC_DEPTH = 640,
  parameter int LOGQ      = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        macs_en,
  input  logic        macs_mode,
  input  logic        macs_signal,
  input  logic [31:0] short_data,
  input  logic [63:0] long_data,
  input  logic [63:0] add_data,
  input  logic        acc_clr,
  output logic [63:0] macs_result,
  output logic        result_valid
);

  localparam logic [10:0] c_last = 11'(ACC_DEPTH - 1);

`ifdef MACS_MODQ_EN
  localparam logic [16:0] c_one  = 17'd1;
  localparam logic [15:0] c_mask = 16'((c_one << LOGQ) - 17'd1);
`else
  localparam logic [15:0] c_mask = 16'hFFFF;
`endif

  generate
    if (ACC_DEPTH < 1 || ACC_DEPTH > 2047 || LOGQ < 1 || LOGQ > 16) begin : g_param_check
      $error("macs_array: ACC_DEPTH or LOGQ out of range");
    end
  endgenerate

  logic [3:0][15:0] w_term;
  logic [3:0][15:0] w_sum;
  logic [3:0][15:0] r_s1_term;
  logic             r_s1_valid;
  logic [3:0][15:0] r_acc;
  logic [10:0]      r_cnt;
  logic             r_result_valid;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [15:0] w_sext;
      logic [15:0] w_prod;
      logic [15:0] w_raw;
      logic [15:0] w_base;

      assign w_sext      = {{8{short_data[8*gi+7]}}, short_data[8*gi +: 8]};
      assign w_prod      = w_sext * long_data[16*gi +: 16];
      assign w_raw       = macs_mode ? add_data[16*gi +: 16] : w_prod;
      assign w_term[gi]  = macs_signal ? (16'd0 - w_raw) : w_raw;
      // First term of each sum overwrites rather than adds.
      assign w_base      = (r_cnt == 11'd0) ? 16'd0 : r_acc[gi];
      assign w_sum[gi]   = (w_base + r_s1_term[gi]) & c_mask;
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_term  <= '0;
    end else begin
      r_s1_valid <= macs_en;
      if (macs_en) begin
        r_s1_term <= w_term;
      end
    end
  end

  // Clear takes priority over a pending stage-2 accumulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_result_valid <= 1'b0;
    end else if (acc_clr) begin
      r_acc          <= '0;
      r_cnt          <= '0;
      r_result_valid <= 1'b0;
    end else if (r_s1_valid) begin
      r_acc <= w_sum;
      if (r_cnt == c_last) begin
        r_cnt          <= '0;
        r_result_valid <= 1'b1;
      end else begin
        r_cnt          <= r_cnt + 11'd1;
        r_result_valid <= 1'b0;
      end
    end else begin
      r_result_valid <= 1'b0;
    end
  end

  assign macs_result  = r_acc;
  assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_macs_array.sv
// ============================================================================
// Module      : tb_macs_array
// Description : Directed self-checking bench for macs_array at four depths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_macs_array;

  logic        clk;
  logic        rstn;
  logic        macs_en;
  logic        macs_mode;
  logic        macs_signal;
  logic [31:0] short_data;
  logic [63:0] long_data;
  logic [63:0] add_data;
  logic        acc_clr;

  logic [63:0] res1, res2, res4, res640;
  logic        rv1, rv2, rv4, rv640;

  int total = 0;
  int bad   = 0;

  macs_array #(.ACC_DEPTH(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .macs_en(macs_en), .macs_mode(macs_mode),
    .macs_signal(macs_signal), .short_data(short_data), .long_data(long_data),
    .add_data(add_data), .acc_clr(acc_clr), .macs_result(res1), .result_valid(rv1));

  macs_array #(.ACC_DEPTH(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .macs_en(macs_en), .macs_mode(macs_mode),
    .macs_signal(macs_signal), .short_data(short_data), .long_data(long_data),
    .add_data(add_data), .acc_clr(acc_clr), .macs_result(res2), .result_valid(rv2));

  macs_array #(.ACC_DEPTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .macs_en(macs_en), .macs_mode(macs_mode),
    .macs_signal(macs_signal), .short_data(short_data), .long_data(long_data),
    .add_data(add_data), .acc_clr(acc_clr), .macs_result(res4), .result_valid(rv4));

  macs_array #(.ACC_DEPTH(640)) u_dut640 (
    .clk(clk), .rstn(rstn), .macs_en(macs_en), .macs_mode(macs_mode),
    .macs_signal(macs_signal), .short_data(short_data), .long_data(long_data),
    .add_data(add_data), .acc_clr(acc_clr), .macs_result(res640), .result_valid(rv640));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] qmask(input logic [15:0] v);
`ifdef MACS_MODQ_EN
    return v & 16'h7FFF;
`else
    return v;
`endif
  endfunction

  function automatic logic [63:0] qmask4(input logic [63:0] v);
    return {qmask(v[63:48]), qmask(v[47:32]), qmask(v[31:16]), qmask(v[15:0])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_term(input logic mode, input logic sig, input logic [31:0] sh,
                          input logic [63:0] lg, input logic [63:0] ad);
    macs_en     = 1'b1;
    macs_mode   = mode;
    macs_signal = sig;
    short_data  = sh;
    long_data   = lg;
    add_data    = ad;
  endtask

  task automatic idle();
    macs_en = 1'b0;
  endtask

  task automatic do_clr();
    idle();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; macs_en = 1'b0; macs_mode = 1'b0; macs_signal = 1'b0;
    short_data = '0; long_data = '0; add_data = '0; acc_clr = 1'b0;
    tick(); tick();
    total++;
    if ({res1, res2, res4, res640} !== 256'h0) begin
      bad++; $display("FAIL reset_result got %h %h %h %h want 0", res1, res2, res4, res640);
    end
    total++;
    if ({rv1, rv2, rv4, rv640} !== 4'b0000) begin
      bad++; $display("FAIL reset_valid got %b want 0000", {rv1, rv2, rv4, rv640});
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single_term();
    do_clr();
    set_term(1'b0, 1'b0, {8'hFF, 8'h02, 8'h01, 8'h00}, {4{16'h0003}}, '0);
    tick();
    idle();
    total++;
    if (rv1 !== 1'b0 || res1 !== 64'h0) begin
      bad++; $display("FAIL single_latency got rv=%b res=%h want rv=0 res=0", rv1, res1);
    end
    tick();
    total++;
    if (res1 !== qmask4({16'hFFFD, 16'h0006, 16'h0003, 16'h0000})) begin
      bad++; $display("FAIL single_result got %h want %h", res1,
                      qmask4({16'hFFFD, 16'h0006, 16'h0003, 16'h0000}));
    end
    total++;
    if (rv1 !== 1'b1) begin
      bad++; $display("FAIL single_valid got %b want 1", rv1);
    end
    tick();
    total++;
    if (rv1 !== 1'b0 || res1 !== qmask4({16'hFFFD, 16'h0006, 16'h0003, 16'h0000})) begin
      bad++; $display("FAIL single_hold got rv=%b res=%h want rv=0 held", rv1, res1);
    end
  endtask

  task automatic test_wrap();
    do_clr();
    for (int k = 0; k < 4; k++) begin
      set_term(1'b0, 1'b0, 32'h01010101, {4{16'h4000}}, '0);
      tick();
    end
    idle();
    total++;
    if (res4 !== qmask4({4{16'hC000}}) || rv4 !== 1'b0) begin
      bad++; $display("FAIL wrap_three got res=%h rv=%b want %h rv=0", res4, rv4, qmask4({4{16'hC000}}));
    end
    tick();
    total++;
    if (res4 !== 64'h0 || rv4 !== 1'b1) begin
      bad++; $display("FAIL wrap_four got res=%h rv=%b want 0 rv=1", res4, rv4);
    end
    tick();
    total++;
    if (rv4 !== 1'b0) begin
      bad++; $display("FAIL wrap_pulse got rv=%b want 0", rv4);
    end
  endtask

  task automatic test_sub_add();
    do_clr();
    set_term(1'b0, 1'b0, 32'h01010101, {4{16'h0003}}, '0);
    tick();
    set_term(1'b1, 1'b1, 32'hDEADBEEF, {4{16'h1234}}, {4{16'h0005}});
    tick();
    idle();
    total++;
    if (res2 !== {4{16'h0003}} || rv2 !== 1'b0) begin
      bad++; $display("FAIL subadd_first got res=%h rv=%b want 0003x4 rv=0", res2, rv2);
    end
    tick();
    total++;
    if (res2 !== qmask4({4{16'hFFFE}}) || rv2 !== 1'b1) begin
      bad++; $display("FAIL subadd_final got res=%h rv=%b want %h rv=1", res2, rv2, qmask4({4{16'hFFFE}}));
    end
  endtask

  task automatic test_clr_collision();
    do_clr();
    set_term(1'b0, 1'b0, 32'h01010101, {4{16'h0007}}, '0);
    tick();
    set_term(1'b0, 1'b0, 32'h01010101, {4{16'h0009}}, '0);
    tick();
    // Clear collides with accumulation of the 9s; the 2s ride into stage 1.
    set_term(1'b0, 1'b0, 32'h01010101, {4{16'h0002}}, '0);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    total++;
    if (res2 !== 64'h0 || rv2 !== 1'b0) begin
      bad++; $display("FAIL clr_win got res=%h rv=%b want 0 rv=0", res2, rv2);
    end
    set_term(1'b0, 1'b0, 32'h01010101, {4{16'h0003}}, '0);
    tick();
    idle();
    total++;
    if (res2 !== {4{16'h0002}} || rv2 !== 1'b0) begin
      bad++; $display("FAIL clr_reload got res=%h rv=%b want 0002x4 rv=0", res2, rv2);
    end
    tick();
    total++;
    if (res2 !== {4{16'h0005}} || rv2 !== 1'b1) begin
      bad++; $display("FAIL clr_count got res=%h rv=%b want 0005x4 rv=1", res2, rv2);
    end
  endtask

  task automatic test_gaps();
    logic [63:0] exp_acc;
    logic [31:0] sh;
    logic [63:0] lg, ad;
    logic        mode, sig;
    logic [15:0] t, s16;
    int          early;
    exp_acc = '0;
    early   = 0;
    do_clr();
    for (int k = 0; k < 640; k++) begin
      sh = $urandom; lg = {$urandom, $urandom}; ad = {$urandom, $urandom};
      mode = 1'($urandom_range(0, 1)); sig = 1'($urandom_range(0, 1));
      for (int l = 0; l < 4; l++) begin
        s16 = {{8{sh[8*l+7]}}, sh[8*l +: 8]};
        t   = mode ? ad[16*l +: 16] : 16'(s16 * lg[16*l +: 16]);
        if (sig) t = 16'd0 - t;
        exp_acc[16*l +: 16] = qmask(exp_acc[16*l +: 16] + t);
      end
      set_term(mode, sig, sh, lg, ad);
      tick();
      idle();
      if (k != 639) begin
        if (rv640 !== 1'b0) early++;
        for (int g = $urandom_range(0, 5); g > 0; g--) begin
          tick();
          if (rv640 !== 1'b0) early++;
        end
      end
    end
    total++;
    if (early !== 0) begin
      bad++; $display("FAIL gaps_early_valid got %0d early pulses want 0", early);
    end
    tick();
    total++;
    if (res640 !== exp_acc || rv640 !== 1'b1) begin
      bad++; $display("FAIL gaps_sum got res=%h rv=%b want %h rv=1", res640, rv640, exp_acc);
    end
  endtask

  task automatic test_reset_mid_sum();
    do_clr();
    for (int k = 0; k < 3; k++) begin
      set_term(1'b0, 1'b0, 32'h01010101, {4{16'h0011}}, '0);
      tick();
    end
    idle();
    tick();
    rstn = 1'b0;
    #1;
    total++;
    if (res4 !== 64'h0 || rv4 !== 1'b0) begin
      bad++; $display("FAIL rst_mid got res=%h rv=%b want 0 rv=0", res4, rv4);
    end
    #2;
    rstn = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      set_term(1'b0, 1'b0, 32'h01010101, {4{16'h0001}}, '0);
      tick();
      total++;
      if (rv4 !== 1'b0) begin
        bad++; $display("FAIL rst_early_valid term %0d got rv=%b want 0", k, rv4);
      end
    end
    idle();
    tick();
    total++;
    if (res4 !== {4{16'h0004}} || rv4 !== 1'b1) begin
      bad++; $display("FAIL rst_new_sum got res=%h rv=%b want 0004x4 rv=1", res4, rv4);
    end
  endtask

  initial begin
    test_reset();
    test_single_term();
    test_wrap();
    test_sub_add();
    test_clr_collision();
    test_gaps();
    test_reset_mid_sum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
